// File: rtl/nbit_seq_shift_unit_if.sv
// Request/response bundle for the multi-cycle shift/rotate unit.
// The master drives requests and consumes results; the slave is the unit itself.
interface nbit_seq_shift_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH) + 1
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [SHW-1:0]   in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_zero;

   modport master (
      output in_valid, in_op, in_a, in_amt, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_zero
   );

   modport slave (
      input  in_valid, in_op, in_a, in_amt, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_zero
   );
endinterface

// File: rtl/nbit_seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one single-bit step per clock until the amount is consumed.
// One operation in flight; valid/ready on both request and result sides.
module nbit_seq_shift_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nbit_seq_shift_unit_if.slave  sif
);
   localparam int unsigned LW = $clog2(WIDTH);

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] r, r_nxt;
   logic             carry, carry_nxt;
   logic [2:0]       op, op_nxt;
   logic [SHW-1:0]   cnt, cnt_nxt;

   logic [SHW-1:0]   amt_eff_c;
   logic [WIDTH-1:0] step_r_c;
   logic             step_carry_c;

   // Effective step count: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
   always_comb begin
      amt_eff_c = '0;
      case (sif.in_op)
         OP_ROL, OP_ROR:         amt_eff_c = SHW'(sif.in_amt[LW-1:0]);
         OP_SLL, OP_SRL, OP_SRA: amt_eff_c = (sif.in_amt > SHW'(WIDTH)) ? SHW'(WIDTH) : sif.in_amt;
         default:                amt_eff_c = '0;
      endcase
   end

   // Single-bit step on the work register.
   always_comb begin
      step_r_c     = r;
      step_carry_c = carry;
      case (op)
         OP_ROL: begin
            step_r_c     = {r[WIDTH-2:0], r[WIDTH-1]};
            step_carry_c = r[WIDTH-1];
         end
         OP_ROR: begin
            step_r_c     = {r[0], r[WIDTH-1:1]};
            step_carry_c = r[0];
         end
         OP_SLL: begin
            step_r_c     = {r[WIDTH-2:0], 1'b0};
            step_carry_c = r[WIDTH-1];
         end
         OP_SRL: begin
            step_r_c     = {1'b0, r[WIDTH-1:1]};
            step_carry_c = r[0];
         end
         OP_SRA: begin
            step_r_c     = {r[WIDTH-1], r[WIDTH-1:1]};
            step_carry_c = r[0];
         end
         default: begin
            step_r_c     = r;
            step_carry_c = carry;
         end
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt = state;
      r_nxt     = r;
      carry_nxt = carry;
      op_nxt    = op;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (sif.in_valid) begin
               r_nxt     = sif.in_a;
               op_nxt    = sif.in_op;
               carry_nxt = 1'b0;
               cnt_nxt   = amt_eff_c;
               state_nxt = (amt_eff_c == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            r_nxt     = step_r_c;
            carry_nxt = step_carry_c;
            cnt_nxt   = cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (sif.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         r     <= '0;
         carry <= 1'b0;
         op    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         r     <= r_nxt;
         carry <= carry_nxt;
         op    <= op_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign sif.in_ready   = (state == IDLE);
   assign sif.out_valid  = (state == DONE);
   assign sif.out_result = r;
   assign sif.out_carry  = carry;
   assign sif.out_zero   = (r == '0);

endmodule

// File: tb/tb_nbit_seq_shift_unit.sv
// Directed-vector bench for nbit_seq_shift_unit at WIDTH=8: table of operations plus
// reset-abort and backpressure sequences.
module tb_nbit_seq_shift_unit;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned SHW   = 4;

   logic clk;
   logic rst_n;

   nbit_seq_shift_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) sif ();

   nbit_seq_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [3:0] amt;
      logic [7:0] exp_res;
      logic       exp_carry;
      logic       exp_zero;
      int         exp_lat;
   } vec_t;

   int n_cmp;
   int n_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request and wait for its result; lat counts edges from the accept edge inclusive.
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [3:0] amt,
                        output logic [7:0] res, output logic carry, output logic zero,
                        output int lat, output bit ok);
      int n;
      ok = 1'b1;
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_op    = op;
      sif.in_a     = a;
      sif.in_amt   = amt;
      n = 0;
      while (!sif.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sif.in_ready) begin
         ok = 1'b0;
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stuck at 0 for op %0d", op);
      end
      @(posedge clk);
      #1;
      sif.in_valid = 1'b0;
      sif.in_a     = 8'hEE;
      sif.in_amt   = 4'hF;
      lat = 1;
      while (!sif.out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!sif.out_valid) begin
         ok = 1'b0;
         n_cmp++;
         n_err++;
         $display("FAIL result_timeout: out_valid never rose for op %0d", op);
      end
      res   = sif.out_result;
      carry = sif.out_carry;
      zero  = sif.out_zero;
   endtask

   vec_t       vecs[14];
   logic [7:0] res;
   logic       car;
   logic       zer;
   int         lat;
   bit         ok;
   bit         seen;

   initial begin
      vecs[0]  = '{3'b000, 8'h81, 4'd1,  8'h03, 1'b1, 1'b0, 2};
      vecs[1]  = '{3'b001, 8'h01, 4'd9,  8'h80, 1'b1, 1'b0, 2};
      vecs[2]  = '{3'b100, 8'h80, 4'd12, 8'hFF, 1'b1, 1'b0, 9};
      vecs[3]  = '{3'b011, 8'h80, 4'd12, 8'h00, 1'b1, 1'b1, 9};
      vecs[4]  = '{3'b010, 8'h5A, 4'd0,  8'h5A, 1'b0, 1'b0, 1};
      vecs[5]  = '{3'b111, 8'h00, 4'd5,  8'h00, 1'b0, 1'b1, 1};
      vecs[6]  = '{3'b010, 8'h81, 4'd3,  8'h08, 1'b0, 1'b0, 4};
      vecs[7]  = '{3'b100, 8'hB4, 4'd2,  8'hED, 1'b0, 1'b0, 3};
      vecs[8]  = '{3'b000, 8'hA5, 4'd8,  8'hA5, 1'b0, 1'b0, 1};
      vecs[9]  = '{3'b001, 8'h96, 4'd3,  8'hD2, 1'b1, 1'b0, 4};
      vecs[10] = '{3'b011, 8'hF0, 4'd4,  8'h0F, 1'b0, 1'b0, 5};
      vecs[11] = '{3'b010, 8'hFF, 4'd8,  8'h00, 1'b1, 1'b1, 9};
      vecs[12] = '{3'b100, 8'h7F, 4'd15, 8'h00, 1'b0, 1'b1, 9};
      vecs[13] = '{3'b000, 8'h81, 4'd15, 8'hC0, 1'b0, 1'b0, 8};

      n_cmp = 0;
      n_err = 0;
      rst_n         = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_op     = 3'b000;
      sif.in_a      = 8'h00;
      sif.in_amt    = 4'h0;
      sif.out_ready = 1'b1;

      // Reset state
      #12;
      check("rst_out_valid", 32'(sif.out_valid), 32'd0);
      check("rst_out_result", 32'(sif.out_result), 32'd0);
      check("rst_out_carry", 32'(sif.out_carry), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(sif.in_ready), 32'd1);

      // Table of directed operations
      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].amt, res, car, zer, lat, ok);
         if (ok) begin
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 32'(car), 32'(vecs[i].exp_carry));
            check($sformatf("vec%0d_zero", i), 32'(zer), 32'(vecs[i].exp_zero));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         end
      end

      // Reset during RUN of ROL amt=5 abandons the operation
      @(negedge clk);
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_op    = 3'b000;
      sif.in_a     = 8'h3C;
      sif.in_amt   = 4'd5;
      @(posedge clk);
      #1;
      sif.in_valid = 1'b0;
      check("abort_in_run", 32'(sif.in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(sif.out_valid), 32'd0);
      check("abort_out_result", 32'(sif.out_result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", 32'(sif.in_ready), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (sif.out_valid) seen = 1'b1;
      end
      check("abort_no_result", 32'(seen), 32'd0);

      // Backpressure: result held while out_ready=0, pending request not taken
      sif.out_ready = 1'b0;
      do_op(3'b010, 8'h11, 4'd2, res, car, zer, lat, ok);
      check("bp_result", 32'(res), 32'h44);
      check("bp_carry", 32'(car), 32'd0);
      @(negedge clk);
      sif.in_valid = 1'b1;
      sif.in_op    = 3'b011;
      sif.in_a     = 8'hFF;
      sif.in_amt   = 4'd1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_valid", k), 32'(sif.out_valid), 32'd1);
         check($sformatf("bp_hold%0d_result", k), 32'(sif.out_result), 32'h44);
         check($sformatf("bp_hold%0d_carry", k), 32'(sif.out_carry), 32'd0);
         check($sformatf("bp_hold%0d_in_ready", k), 32'(sif.in_ready), 32'd0);
      end
      @(negedge clk);
      sif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 32'(sif.out_valid), 32'd0);
      check("bp_release_in_ready", 32'(sif.in_ready), 32'd1);
      do_op(3'b011, 8'hFF, 4'd1, res, car, zer, lat, ok);
      if (ok) begin
         check("bp_next_result", 32'(res), 32'h7F);
         check("bp_next_carry", 32'(car), 32'd1);
         check("bp_next_latency", 32'(lat), 32'd2);
      end
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
